// File: rtl/watch_calendar.sv
// watch_calendar: binary calendar / time-of-day counter.
// Advances second..year on each one-second enable, keeps a day-of-week count,
// accepts a validated load, and drives a 12/24-hour display hour.
//
// Handshake: clk1sec and set_time are single-cycle qualifiers sampled at every
// rising edge; there is no ready/backpressure. Every registered field, wday,
// set_err and the rollover strobes reflect the sampled request one cycle later,
// and the strobes and set_err are valid for exactly that one cycle.
module watch_calendar #(
   parameter int YEAR_W    = 8,
   parameter int YEAR_BASE = 2000,
   parameter int RST_YEAR  = 21,
   parameter int RST_MONTH = 5,
   parameter int RST_DAY   = 30,
   parameter int RST_WDAY  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk1sec,
   input  logic              set_time,
   input  logic [YEAR_W+39:0] bin_time,
   input  logic [2:0]        set_wday,
   input  logic              mode_12h,
   output logic [YEAR_W-1:0] year,
   output logic [7:0]        month,
   output logic [7:0]        day,
   output logic [7:0]        hour,
   output logic [7:0]        minute,
   output logic [7:0]        second,
   output logic [2:0]        wday,
   output logic [7:0]        hour_disp,
   output logic              pm,
   output logic              set_err,
   output logic              sec_pulse,
   output logic              min_pulse,
   output logic              day_pulse
);

   localparam logic [YEAR_W-1:0] RST_YEAR_V  = YEAR_W'(RST_YEAR);
   localparam logic [7:0]        RST_MONTH_V = 8'(RST_MONTH);
   localparam logic [7:0]        RST_DAY_V   = 8'(RST_DAY);
   localparam logic [2:0]        RST_WDAY_V  = 3'(RST_WDAY);

   // Gregorian leap rule on the absolute year (offset plus base).
   function automatic logic is_leap(input logic [YEAR_W-1:0] y);
      logic [31:0] full;
      full = 32'(YEAR_BASE) + 32'(y);
      return ((full % 32'd4 == 32'd0) && (full % 32'd100 != 32'd0)) ||
             (full % 32'd400 == 32'd0);
   endfunction

   // Number of days in month m of year offset y.
   function automatic logic [7:0] max_date(input logic [7:0] m,
                                           input logic [YEAR_W-1:0] y);
      logic [7:0] d;
      case (m)
         8'd2:                      d = is_leap(y) ? 8'd29 : 8'd28;
         8'd4, 8'd6, 8'd9, 8'd11:   d = 8'd30;
         default:                   d = 8'd31;
      endcase
      return d;
   endfunction

   // Load value split into its fields.
   logic [YEAR_W-1:0] ld_year;
   logic [7:0]        ld_month;
   logic [7:0]        ld_day;
   logic [7:0]        ld_hour;
   logic [7:0]        ld_minute;
   logic [7:0]        ld_second;

   assign ld_year   = bin_time[YEAR_W+39:40];
   assign ld_month  = bin_time[39:32];
   assign ld_day    = bin_time[31:24];
   assign ld_hour   = bin_time[23:16];
   assign ld_minute = bin_time[15:8];
   assign ld_second = bin_time[7:0];

   logic load_ok;

   // A load is legal only if it names a real date/time and weekday.
   always_comb begin
      load_ok = (ld_month >= 8'd1) && (ld_month <= 8'd12) &&
                (ld_day >= 8'd1) && (ld_day <= max_date(ld_month, ld_year)) &&
                (ld_hour < 8'd24) && (ld_minute < 8'd60) &&
                (ld_second < 8'd60) && (set_wday < 3'd7);
   end

   // Carry chain for one tick; every stage resolves in the same cycle.
   logic              sec_wrap;
   logic              min_wrap;
   logic              hour_wrap;
   logic              day_wrap;
   logic              month_wrap;
   logic [YEAR_W-1:0] nxt_year;
   logic [7:0]        nxt_month;
   logic [7:0]        nxt_day;
   logic [7:0]        nxt_hour;
   logic [7:0]        nxt_minute;
   logic [7:0]        nxt_second;
   logic [2:0]        nxt_wday;

   // Next-second values computed from the current registered fields.
   always_comb begin
      sec_wrap   = (second == 8'd59);
      min_wrap   = sec_wrap && (minute == 8'd59);
      hour_wrap  = min_wrap && (hour == 8'd23);
      day_wrap   = hour_wrap && (day == max_date(month, year));
      month_wrap = day_wrap && (month == 8'd12);

      nxt_second = sec_wrap ? 8'd0 : second + 8'd1;
      nxt_minute = minute;
      nxt_hour   = hour;
      nxt_day    = day;
      nxt_month  = month;
      nxt_year   = year;
      nxt_wday   = wday;

      if (sec_wrap) begin
         nxt_minute = min_wrap ? 8'd0 : minute + 8'd1;
      end
      if (min_wrap) begin
         nxt_hour = hour_wrap ? 8'd0 : hour + 8'd1;
      end
      if (hour_wrap) begin
         nxt_day  = day_wrap ? 8'd1 : day + 8'd1;
         nxt_wday = (wday == 3'd6) ? 3'd0 : wday + 3'd1;
      end
      if (day_wrap) begin
         nxt_month = month_wrap ? 8'd1 : month + 8'd1;
      end
      if (month_wrap) begin
         // Natural truncation wraps the top year back to zero.
         nxt_year = year + 1'b1;
      end
   end

   // Registered calendar state: reset, then load (priority), then tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         year      <= RST_YEAR_V;
         month     <= RST_MONTH_V;
         day       <= RST_DAY_V;
         hour      <= 8'd0;
         minute    <= 8'd0;
         second    <= 8'd0;
         wday      <= RST_WDAY_V;
         set_err   <= 1'b0;
         sec_pulse <= 1'b0;
         min_pulse <= 1'b0;
         day_pulse <= 1'b0;
      end else begin
         set_err   <= 1'b0;
         sec_pulse <= 1'b0;
         min_pulse <= 1'b0;
         day_pulse <= 1'b0;
         if (set_time) begin
            if (load_ok) begin
               year   <= ld_year;
               month  <= ld_month;
               day    <= ld_day;
               hour   <= ld_hour;
               minute <= ld_minute;
               second <= ld_second;
               wday   <= set_wday;
            end else begin
               set_err <= 1'b1;
            end
         end else if (clk1sec) begin
            year      <= nxt_year;
            month     <= nxt_month;
            day       <= nxt_day;
            hour      <= nxt_hour;
            minute    <= nxt_minute;
            second    <= nxt_second;
            wday      <= nxt_wday;
            sec_pulse <= 1'b1;
            min_pulse <= sec_wrap;
            day_pulse <= hour_wrap;
         end
      end
   end

   // Display hour follows hour and mode_12h with no added latency.
   always_comb begin
      hour_disp = hour;
      pm        = 1'b0;
      if (mode_12h) begin
         pm = (hour >= 8'd12);
         if (hour == 8'd0) begin
            hour_disp = 8'd12;
         end else if (hour > 8'd12) begin
            hour_disp = hour - 8'd12;
         end
      end
   end

endmodule

// File: tb/tb_watch_calendar.sv
// Bench for watch_calendar: directed calendar corner cases followed by random
// ticks, loads and display-mode changes, checked against a seconds-of-day model.
module tb_watch_calendar;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clk1sec = 1'b0;
   logic        set_time = 1'b0;
   logic [47:0] bin_time = '0;
   logic [2:0]  set_wday = '0;
   logic        mode_12h = 1'b0;
   logic [7:0]  year;
   logic [7:0]  month, day, hour, minute, second, hour_disp;
   logic [2:0]  wday;
   logic        pm, set_err, sec_pulse, min_pulse, day_pulse;

   // Clock
   always #5 clk = ~clk;

   watch_calendar #(
      .YEAR_W(8), .YEAR_BASE(2000), .RST_YEAR(21),
      .RST_MONTH(5), .RST_DAY(30), .RST_WDAY(0)
   ) dut (
      .clk(clk), .rst(rst), .clk1sec(clk1sec), .set_time(set_time),
      .bin_time(bin_time), .set_wday(set_wday), .mode_12h(mode_12h),
      .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
      .second(second), .wday(wday), .hour_disp(hour_disp), .pm(pm),
      .set_err(set_err), .sec_pulse(sec_pulse), .min_pulse(min_pulse),
      .day_pulse(day_pulse)
   );

   // Scoreboard
   logic [63:0] exp_q[$];
   int checks = 0;
   int passed = 0;
   int cycle_no = 0;

   // Reference model: date plus seconds-of-day.
   int   m_year, m_month, m_day, m_sod, m_wday;
   logic m_err, m_sp, m_mp, m_dp;
   logic cur_mode = 1'b0;

   function automatic int days_in(input int m, input int yoff);
      int  y;
      bit  leap;
      y    = 2000 + yoff;
      leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
      if (m == 2) return leap ? 29 : 28;
      if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      return 31;
   endfunction

   function automatic logic [47:0] mk(input int y, input int mo, input int d,
                                      input int h, input int mi, input int s);
      return {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
   endfunction

   function automatic logic [63:0] exp_vec(input logic md);
      int h, hd;
      h  = m_sod / 3600;
      hd = md ? ((h == 0) ? 12 : ((h > 12) ? h - 12 : h)) : h;
      return {8'(m_year), 8'(m_month), 8'(m_day), 8'(h),
              8'((m_sod / 60) % 60), 8'(m_sod % 60), 3'(m_wday),
              m_err, m_sp, m_mp, m_dp, 8'(hd), (md && h >= 12)};
   endfunction

   task automatic model_step(input logic r, input logic s, input logic t,
                             input logic [47:0] bt, input logic [2:0] sw);
      int y, mo, d, h, mi, sc;
      m_err = 1'b0; m_sp = 1'b0; m_mp = 1'b0; m_dp = 1'b0;
      if (r) begin
         m_year = 21; m_month = 5; m_day = 30; m_sod = 0; m_wday = 0;
      end else if (s) begin
         y = int'(bt[47:40]); mo = int'(bt[39:32]); d = int'(bt[31:24]);
         h = int'(bt[23:16]); mi = int'(bt[15:8]); sc = int'(bt[7:0]);
         if (mo >= 1 && mo <= 12 && d >= 1 && d <= days_in(mo, y) &&
             h < 24 && mi < 60 && sc < 60 && int'(sw) < 7) begin
            m_year = y; m_month = mo; m_day = d;
            m_sod = h * 3600 + mi * 60 + sc; m_wday = int'(sw);
         end else begin
            m_err = 1'b1;
         end
      end else if (t) begin
         m_sod = m_sod + 1;
         m_sp  = 1'b1;
         m_mp  = (m_sod % 60 == 0);
         if (m_sod == 86400) begin
            m_sod  = 0;
            m_dp   = 1'b1;
            m_wday = (m_wday + 1) % 7;
            m_day  = m_day + 1;
            if (m_day > days_in(m_month, m_year)) begin
               m_day   = 1;
               m_month = m_month + 1;
               if (m_month > 12) begin
                  m_month = 1;
                  m_year  = (m_year + 1) % 256;
               end
            end
         end
      end
   endtask

   // Driver tasks: drive on the falling edge, push the expected outcome.
   task automatic drive(input logic r, input logic s, input logic t,
                        input logic [47:0] bt, input logic [2:0] sw);
      @(negedge clk);
      rst = r; set_time = s; clk1sec = t; bin_time = bt; set_wday = sw;
      mode_12h = cur_mode;
      model_step(r, s, t, bt, sw);
      exp_q.push_back(exp_vec(cur_mode));
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, '0, 3'd0);
   endtask

   task automatic tick();
      drive(1'b0, 1'b0, 1'b1, '0, 3'd0);
   endtask

   task automatic load(input logic [47:0] bt, input logic [2:0] sw);
      drive(1'b0, 1'b1, 1'b0, bt, sw);
   endtask

   // Monitor: one registered result per cycle, compared after the edge.
   initial begin
      logic [63:0] got, e;
      forever begin
         @(posedge clk);
         #1;
         cycle_no++;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {year, month, day, hour, minute, second, wday, set_err,
                   sec_pulse, min_pulse, day_pulse, hour_disp, pm};
            checks++;
            if (got === e) passed++;
            else $display("FAIL state@cycle%0d got=%h exp=%h (y,mo,d,h,mi,s,wd|err,sp,mp,dp|hd,pm)",
                          cycle_no, got, e);
         end
      end
   end

   // Stimulus
   initial begin
      int r;
      int y, mo, d;
      m_year = 0; m_month = 1; m_day = 1; m_sod = 0; m_wday = 0;
      m_err = 0; m_sp = 0; m_mp = 0; m_dp = 0;

      // Reset overrides simultaneous load and tick
      drive(1'b1, 1'b1, 1'b1, mk(1, 1, 1, 1, 1, 1), 3'd3);
      idle();
      tick();

      // Leap and non-leap February ends
      load(mk(24, 2, 28, 23, 59, 59), 3'd2); tick(); tick();
      load(mk(100, 2, 28, 23, 59, 59), 3'd0); tick();
      load(mk(0, 2, 28, 23, 59, 59), 3'd5); tick();
      load(mk(23, 2, 28, 23, 59, 59), 3'd5); tick();

      // Year wrap with weekday wrap
      load(mk(255, 12, 31, 23, 59, 59), 3'd6); tick(); idle();

      // Rejected loads keep fields; set_err only for one cycle each
      load(mk(23, 4, 31, 10, 0, 0), 3'd1); idle();
      load(mk(23, 2, 29, 10, 0, 0), 3'd1); idle();
      load(mk(23, 0, 1, 0, 0, 0), 3'd1);
      load(mk(23, 13, 1, 0, 0, 0), 3'd1);
      load(mk(23, 1, 0, 0, 0, 0), 3'd1);
      load(mk(23, 1, 1, 24, 0, 0), 3'd1);
      load(mk(23, 1, 1, 0, 60, 0), 3'd1);
      load(mk(23, 1, 1, 0, 0, 60), 3'd1);
      load(mk(23, 1, 1, 0, 0, 0), 3'd7);
      load(mk(23, 2, 28, 8, 0, 0), 3'd1); idle();

      // Load wins over a simultaneous tick
      drive(1'b0, 1'b1, 1'b1, mk(23, 6, 15, 10, 20, 30), 3'd4); idle();

      // 12-hour display at the interesting hours
      cur_mode = 1'b1;
      foreach (exp_q[i]) ; // no-op keeps queue untouched
      load(mk(23, 6, 15, 0, 0, 0), 3'd4); idle();
      load(mk(23, 6, 15, 11, 59, 59), 3'd4); tick();
      load(mk(23, 6, 15, 13, 0, 0), 3'd4); idle();
      load(mk(23, 6, 15, 23, 59, 58), 3'd4); tick(); tick();

      // Mode toggles between ticks must not disturb the count
      load(mk(23, 6, 15, 14, 59, 58), 3'd4);
      for (int i = 0; i < 6; i++) begin
         cur_mode = ~cur_mode;
         if (i % 2 == 0) tick(); else idle();
      end

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            load(mk($urandom_range(0, 255), $urandom_range(0, 13),
                    $urandom_range(0, 32), $urandom_range(20, 24),
                    $urandom_range(57, 60), $urandom_range(57, 60)),
                 3'($urandom_range(0, 7)));
         end else if (r < 8) begin
            y  = $urandom_range(0, 255);
            mo = $urandom_range(1, 12);
            d  = days_in(mo, y) - $urandom_range(0, 1);
            load(mk(y, mo, d, 23, 59, $urandom_range(50, 59)),
                 3'($urandom_range(0, 6)));
         end else if (r < 12) begin
            cur_mode = ~cur_mode;
            drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), '0, 3'd0);
         end else if (r < 14) begin
            drive(1'b0, 1'b1, 1'b1, mk($urandom_range(0, 255), $urandom_range(1, 12),
                    $urandom_range(1, 28), $urandom_range(0, 23),
                    $urandom_range(0, 59), $urandom_range(0, 59)),
                  3'($urandom_range(0, 6)));
         end else begin
            drive(1'b0, 1'b0, 1'($urandom_range(0, 9) < 7), '0, 3'd0);
         end
      end
      idle();

      // Drain with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain got=%0d pending exp=0 pending", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
